// File: rtl/regfile_seq.sv
// regfile_seq: four-state command sequencer (IDLE/READ/EXEC/WB) that reads two
// operands from an external register file, runs a small ALU, and writes the
// result back. One command is in flight at a time, so no forwarding is needed.
module regfile_seq #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              rf_readA,
    output logic              rf_readB,
    output logic [ADDR_W-1:0] rf_rdAddrA,
    output logic [ADDR_W-1:0] rf_rdAddrB,
    input  logic [DATA_W-1:0] rf_rdDataA,
    input  logic [DATA_W-1:0] rf_rdDataB,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_wrAddr,
    output logic [DATA_W-1:0] rf_wrData,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              flag_z,
    output logic              flag_c,
    output logic [15:0]       op_count
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_MOVI = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [ADDR_W-1:0]   rd_q, rd_d;
    logic [ADDR_W-1:0]   rs1_q, rs1_d;
    logic [ADDR_W-1:0]   rs2_q, rs2_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                flag_z_q, flag_z_d;
    logic                flag_c_q, flag_c_d;
    logic [15:0]         op_count_q, op_count_d;
    // Output flags are registered from the next-state decode so they line up
    // exactly with the state they describe.
    logic                ready_q, ready_d;
    logic                read_en_q, read_en_d;
    logic                write_q, write_d;
    logic                done_q, done_d;
    logic [DATA_W:0]     alu;

    // ALU: 17-bit result, bit DATA_W is carry (ADD) or borrow (SUB).
    always_comb begin
        alu = '0;
        case (op_q)
            OP_ADD:  alu = {1'b0, rf_rdDataA} + {1'b0, rf_rdDataB};
            OP_SUB:  alu = {1'b0, rf_rdDataA} - {1'b0, rf_rdDataB};
            OP_AND:  alu = {1'b0, rf_rdDataA & rf_rdDataB};
            OP_OR:   alu = {1'b0, rf_rdDataA | rf_rdDataB};
            OP_XOR:  alu = {1'b0, rf_rdDataA ^ rf_rdDataB};
            OP_SHL:  alu = {1'b0, rf_rdDataA << rf_rdDataB[3:0]};
            OP_SHR:  alu = {1'b0, rf_rdDataA >> rf_rdDataB[3:0]};
            OP_MOVI: alu = {1'b0, imm_q};
            default: alu = '0;
        endcase
    end

    // Next-state, command latching and result/flag/counter updates.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rd_d       = rd_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        imm_d      = imm_q;
        result_d   = result_q;
        flag_z_d   = flag_z_q;
        flag_c_d   = flag_c_q;
        op_count_d = op_count_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    rd_d    = cmd_rd;
                    rs1_d   = cmd_rs1;
                    rs2_d   = cmd_rs2;
                    imm_d   = cmd_imm;
                    state_d = S_READ;
                end
            end
            S_READ: state_d = S_EXEC;
            S_EXEC: begin
                // Results become visible in the WB cycle, alongside done.
                result_d   = alu[DATA_W-1:0];
                flag_c_d   = alu[DATA_W];
                flag_z_d   = (alu[DATA_W-1:0] == '0);
                op_count_d = op_count_q + 16'd1;
                state_d    = S_WB;
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ready_d   = (state_d == S_IDLE);
        read_en_d = (state_d == S_READ) && (op_d != OP_MOVI);
        // R0 is hard-wired: writes to it are suppressed.
        write_d   = (state_d == S_WB) && (rd_d != '0);
        done_d    = (state_d == S_WB);
    end

    // State registers; reset aborts any in-flight command.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            result_q   <= '0;
            flag_z_q   <= 1'b0;
            flag_c_q   <= 1'b0;
            op_count_q <= '0;
            ready_q    <= 1'b1;
            read_en_q  <= 1'b0;
            write_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            imm_q      <= imm_d;
            result_q   <= result_d;
            flag_z_q   <= flag_z_d;
            flag_c_q   <= flag_c_d;
            op_count_q <= op_count_d;
            ready_q    <= ready_d;
            read_en_q  <= read_en_d;
            write_q    <= write_d;
            done_q     <= done_d;
        end
    end

    // Register-file strobes are masked while reset is held so nothing leaks
    // out during the reset cycle itself.
    assign cmd_ready  = ready_q && !reset;
    assign rf_readA   = read_en_q && !reset;
    assign rf_readB   = read_en_q && !reset;
    assign rf_write   = write_q && !reset;
    assign rf_rdAddrA = rs1_q;
    assign rf_rdAddrB = rs2_q;
    assign rf_wrAddr  = rd_q;
    assign rf_wrData  = result_q;
    assign done       = done_q;
    assign result     = result_q;
    assign flag_z     = flag_z_q;
    assign flag_c     = flag_c_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_regfile_seq.sv
// tb_regfile_seq: directed bench for regfile_seq with a behavioural register
// file (registered reads, one cycle after the enable).
module tb_regfile_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [4:0]  cmd_rd, cmd_rs1, cmd_rs2;
    logic [15:0] cmd_imm;
    logic        rf_readA, rf_readB;
    logic [4:0]  rf_rdAddrA, rf_rdAddrB;
    logic [15:0] rf_rdDataA, rf_rdDataB;
    logic        rf_write;
    logic [4:0]  rf_wrAddr;
    logic [15:0] rf_wrData;
    logic        done;
    logic [15:0] result;
    logic        flag_z, flag_c;
    logic [15:0] op_count;

    int n_vec = 0;
    int n_err = 0;
    int n_wr  = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    regfile_seq #(.DATA_W(16), .ADDR_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rd     (cmd_rd),
        .cmd_rs1    (cmd_rs1),
        .cmd_rs2    (cmd_rs2),
        .cmd_imm    (cmd_imm),
        .rf_readA   (rf_readA),
        .rf_readB   (rf_readB),
        .rf_rdAddrA (rf_rdAddrA),
        .rf_rdAddrB (rf_rdAddrB),
        .rf_rdDataA (rf_rdDataA),
        .rf_rdDataB (rf_rdDataB),
        .rf_write   (rf_write),
        .rf_wrAddr  (rf_wrAddr),
        .rf_wrData  (rf_wrData),
        .done       (done),
        .result     (result),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .op_count   (op_count)
    );

    // Behavioural register file: 32 x 16, registered read ports.
    logic [15:0] mem [32] = '{default: 16'h0000};
    always @(posedge clk) begin
        if (rf_readA) rf_rdDataA <= mem[rf_rdAddrA];
        if (rf_readB) rf_rdDataB <= mem[rf_rdAddrB];
        if (rf_write) mem[rf_wrAddr] <= rf_wrData;
        if (rf_write) n_wr <= n_wr + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one command at the current negedge (IDLE) and check every phase.
    // With hold=1 cmd_valid stays high with the same fields through the
    // command, and the task returns at the next IDLE negedge still driving it.
    task automatic run_cmd(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [15:0] imm,
                           input logic [15:0] exp_res, input logic ez, input logic ec,
                           input bit hold);
        string t;
        t = $sformatf("op%0d_rd%0d_rs%0d_%0d", op, rd, rs1, rs2);
        check({t, ".ready_N"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        @(negedge clk);                         // N+1: READ
        if (!hold) begin
            cmd_valid = 1'b0;
            cmd_op = ~op; cmd_rd = ~rd; cmd_rs1 = ~rs1; cmd_rs2 = ~rs2; cmd_imm = ~imm;
        end
        check({t, ".ready_N1"}, cmd_ready, 0);
        check({t, ".readA"}, rf_readA, (op != 3'b111));
        check({t, ".readB"}, rf_readB, (op != 3'b111));
        if (op != 3'b111) begin
            check({t, ".addrA"}, rf_rdAddrA, rs1);
            check({t, ".addrB"}, rf_rdAddrB, rs2);
        end
        @(negedge clk);                         // N+2: EXEC
        check({t, ".ready_N2"}, cmd_ready, 0);
        check({t, ".readA_N2"}, rf_readA, 0);
        check({t, ".done_N2"}, done, 0);
        @(negedge clk);                         // N+3: WB
        exp_cnt++;
        check({t, ".ready_N3"}, cmd_ready, 0);
        check({t, ".done"}, done, 1);
        check({t, ".write"}, rf_write, (rd != 5'd0));
        check({t, ".wrAddr"}, rf_wrAddr, rd);
        check({t, ".wrData"}, rf_wrData, exp_res);
        check({t, ".result"}, result, exp_res);
        check({t, ".flag_z"}, flag_z, ez);
        check({t, ".flag_c"}, flag_c, ec);
        check({t, ".op_count"}, op_count, exp_cnt);
        @(negedge clk);                         // N+4: IDLE again
        check({t, ".ready_N4"}, cmd_ready, 1);
        check({t, ".done_N4"}, done, 0);
        check({t, ".write_N4"}, rf_write, 0);
        $display("cmd op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h -> result=%h z=%0d c=%0d cnt=%0d",
                 op, rd, rs1, rs2, imm, result, flag_z, flag_c, op_count);
    endtask

    int w0;

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b1;                       // must be ignored during reset
        cmd_op = 3'b111; cmd_rd = 5'd1; cmd_rs1 = 5'd0; cmd_rs2 = 5'd0; cmd_imm = 16'h5555;
        repeat (3) @(negedge clk);
        check("rst.write", rf_write, 0);
        check("rst.readA", rf_readA, 0);
        check("rst.readB", rf_readB, 0);
        check("rst.done", done, 0);
        reset = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("rst.ready", cmd_ready, 1);
        check("rst.op_count", op_count, 0);
        check("rst.result", result, 0);
        check("rst.flag_z", flag_z, 0);
        check("rst.flag_c", flag_c, 0);

        //      op      rd     rs1    rs2    imm       result    z     c
        run_cmd(3'b111, 5'd1,  5'd0,  5'd0,  16'h1234, 16'h1234, 1'b0, 1'b0, 0);
        run_cmd(3'b111, 5'd1,  5'd0,  5'd0,  16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 0);
        run_cmd(3'b111, 5'd2,  5'd0,  5'd0,  16'h0001, 16'h0001, 1'b0, 1'b0, 0);
        run_cmd(3'b000, 5'd3,  5'd1,  5'd2,  16'h0000, 16'h0000, 1'b1, 1'b1, 0); // ADD wrap
        run_cmd(3'b111, 5'd1,  5'd0,  5'd0,  16'h0005, 16'h0005, 1'b0, 1'b0, 0);
        run_cmd(3'b111, 5'd2,  5'd0,  5'd0,  16'h0007, 16'h0007, 1'b0, 1'b0, 0);
        run_cmd(3'b001, 5'd4,  5'd1,  5'd2,  16'h0000, 16'hFFFE, 1'b0, 1'b1, 0); // 5-7 borrow
        run_cmd(3'b001, 5'd12, 5'd2,  5'd1,  16'h0000, 16'h0002, 1'b0, 1'b0, 0); // 7-5
        run_cmd(3'b111, 5'd1,  5'd0,  5'd0,  16'h8001, 16'h8001, 1'b0, 1'b0, 0);
        run_cmd(3'b111, 5'd2,  5'd0,  5'd0,  16'h0011, 16'h0011, 1'b0, 1'b0, 0);
        run_cmd(3'b110, 5'd6,  5'd1,  5'd2,  16'h0000, 16'h4000, 1'b0, 1'b0, 0); // SHR by 1
        run_cmd(3'b101, 5'd7,  5'd1,  5'd2,  16'h0000, 16'h0002, 1'b0, 1'b0, 0); // SHL by 1
        run_cmd(3'b010, 5'd8,  5'd1,  5'd2,  16'h0000, 16'h0001, 1'b0, 1'b0, 0); // AND
        run_cmd(3'b011, 5'd13, 5'd1,  5'd2,  16'h0000, 16'h8011, 1'b0, 1'b0, 0); // OR
        run_cmd(3'b100, 5'd14, 5'd1,  5'd2,  16'h0000, 16'h8010, 1'b0, 1'b0, 0); // XOR
        run_cmd(3'b111, 5'd0,  5'd0,  5'd0,  16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 0); // R0 protected
        run_cmd(3'b011, 5'd5,  5'd0,  5'd0,  16'h0000, 16'h0000, 1'b1, 1'b0, 0); // r0 reads 0
        // Back-to-back with cmd_valid held: second reads first's destination.
        run_cmd(3'b000, 5'd9,  5'd2,  5'd2,  16'h0000, 16'h0022, 1'b0, 1'b0, 1);
        run_cmd(3'b000, 5'd10, 5'd9,  5'd9,  16'h0000, 16'h0044, 1'b0, 1'b0, 0);
        check("mem.r0", mem[0], 16'h0000);
        check("mem.r10", mem[10], 16'h0044);

        // Reset asserted during EXEC aborts the command.
        w0 = n_wr;
        cmd_valid = 1'b1;
        cmd_op = 3'b000; cmd_rd = 5'd11; cmd_rs1 = 5'd1; cmd_rs2 = 5'd2; cmd_imm = 16'h0;
        @(negedge clk);                         // READ
        cmd_valid = 1'b0;
        @(negedge clk);                         // EXEC
        reset = 1'b1;
        check("abort.write_exec", rf_write, 0);
        @(negedge clk);
        check("abort.write", rf_write, 0);
        check("abort.done", done, 0);
        check("abort.op_count_rst", op_count, 0);
        reset = 1'b0;
        @(negedge clk);
        check("abort.ready", cmd_ready, 1);
        check("abort.op_count", op_count, 0);
        check("abort.result", result, 0);
        check("abort.no_write", n_wr, w0);
        check("abort.mem_r11", mem[11], 16'h0000);
        $display("abort: op_count=%0d ready=%0d writes=%0d", op_count, cmd_ready, n_wr - w0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_seq.md
REGFILE_SEQ -- requirements
Module: regfile_seq

Interface
REQ-001 Parameter: DATA_W, 16, operand/result width; fixed at 16 for this release.
REQ-002 Parameter: ADDR_W, 5, register address width (32 registers).
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  sequencer can accept a command; high only in IDLE.
REQ-007 cmd_op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MOVI.
REQ-008 cmd_rd, cmd_rs1, cmd_rs2  input  5 each  destination and source register addresses.
REQ-009 cmd_imm  input  16  immediate for MOVI.
REQ-010 rf_readA, rf_readB  output  1 each  read enables to the register file.
REQ-011 rf_rdAddrA, rf_rdAddrB  output  5 each  read addresses.
REQ-012 rf_rdDataA, rf_rdDataB  input  16 each  read data; the register file registers them one cycle after the enable.
REQ-013 rf_write  output  1  write enable; rf_wrAddr  output  5; rf_wrData  output  16.
REQ-014 done  output  1  one-cycle pulse per completed command.
REQ-015 result  output  16  last result; flag_z, flag_c  output  1 each  zero and carry/borrow flags.
REQ-016 op_count  output  16  completed-command counter.

Function
REQ-017 FSM states IDLE, READ, EXEC, WB; IDLE->READ on cmd_valid&&cmd_ready; READ->EXEC, EXEC->WB, WB->IDLE unconditionally.
REQ-018 Accept cycle: op, rd, rs1, rs2 and imm latch into internal registers; later cmd_* changes do not affect the command in flight.
REQ-019 READ: rf_readA=1 with rf_rdAddrA=rs1 and rf_readB=1 with rf_rdAddrB=rs2, except for MOVI, where both enables are 0; enables are 0 in all other states.
REQ-020 EXEC: compute from rf_rdDataA (A) and rf_rdDataB (B); register the 16-bit result and 17th bit.
REQ-021 Arithmetic: ADD = A+B, with carry = bit 16; SUB = A-B mod 2^16, with carry = borrow (A<B unsigned).
REQ-022 Logic ops: AND/OR/XOR are bitwise, carry=0.
REQ-023 Shift ops: SHL = A<<B[3:0] and SHR = logical A>>B[3:0], carry=0; B[15:4] is ignored.
REQ-024 MOVI: result = latched imm, carry=0.
REQ-025 WB: rf_write=1, rf_wrAddr=rd, rf_wrData=registered result; done=1 for exactly this cycle.
REQ-026 WB flag and counter updates: result, flag_z (result==0) and flag_c update on the WB edge and otherwise hold; op_count increments by 1 at WB and wraps 0xFFFF->0x0000.
REQ-027 R0 is read-only: when rd==0, rf_write stays 0 in WB; done, result, flags and op_count still update.
REQ-028 Latency and throughput: accept at cycle N gives READ N+1, EXEC N+2, WB N+3, IDLE/ready at N+4; the next command can be accepted in cycle N+4; throughput is 1 command per 4 cycles.
REQ-029 Read-after-write: no forwarding is needed because WB completes before any later READ; this correct behaviour is a requirement.
REQ-030 cmd_valid outside IDLE is ignored: no accept occurs and the command must be held by the requester.

Reset
REQ-031 Reset sampled high drives: state IDLE, result 0x0000, flag_z 0, flag_c 0, op_count 0x0000, done 0, and all internal command registers 0.
REQ-032 During reset, rf_write, rf_readA and rf_readB are gated with !reset so that no register-file access occurs.
REQ-033 Reset in READ, EXEC or WB aborts the command: no write occurs and op_count does not increment.
REQ-034 Reset in IDLE with cmd_valid high: the command is not accepted.
REQ-035 cmd_ready=1 in the first cycle after reset deasserts.

Verification
REQ-036 MOVI rd=1, imm=0x1234 -> cycle N+3: rf_write=1, rf_wrAddr=1, rf_wrData=0x1234, done=1; flag_z=0, op_count=1.
REQ-037 With r1=0xFFFF and r2=0x0001, ADD rd=3, rs1=1, rs2=2 -> WB writes r3=0x0000, flag_z=1, flag_c=1.
REQ-038 With r1=0x0005 and r2=0x0007, SUB rd=4 -> r4=0xFFFE, flag_c=1; with r1=0x8001, SHR by 0x0011 (B[3:0]=1) -> 0x4000.
REQ-039 MOVI rd=0, imm=0xBEEF -> rf_write stays 0; done=1, result=0xBEEF, op_count increments; a subsequent read of r0 returns 0x0000.
REQ-040 ADD issued then reset asserted in EXEC -> no rf_write pulse, op_count=0, cmd_ready=1 in the cycle after reset drops.
REQ-041 cmd_valid held high for two commands -> accepts occur at cycles N and N+4; the second reads the first's result via rs1=rd (RAW correct); cmd_ready is 0 in cycles N+1..N+3.
